gs_test_sequencer: RTL
======================

# gs_test_sequencer

Sequencer for one evoked-potential acquisition run. It accepts a 32-bit command from the host write stream `gs_start_test` and emits a click stimulus pulse. It then captures a decimated number of 16-bit ADC samples into an internal FIFO that drains to the host read stream `gs_raw_signal`, ending with end-of-file. It sits between the Xillybus core ports and the analog front end.

## Interface
Parameters:
- `FIFO_AW`, 10: FIFO address width; depth = 2^FIFO_AW words.
- `STIM_LEN`, 100: stimulus pulse length in `bus_clk` cycles (≥1).

Ports:
- `bus_clk`  in  1  sole clock; all logic on rising edge.
- `bus_rst_n`  in  1  asynchronous, active-low reset.
- `cmd_wren`  in  1  host write strobe (`user_w_gs_start_test_wren`).
- `cmd_data`  in  32  command word (`user_w_gs_start_test_data`).
- `cmd_full`  out  1  to `user_w_gs_start_test_full`.
- `rd_open`  in  1  `user_r_gs_raw_signal_open`.
- `rd_en`  in  1  `user_r_gs_raw_signal_rden`.
- `rd_data`  out  16  `user_r_gs_raw_signal_data`.
- `rd_empty`  out  1  `user_r_gs_raw_signal_empty`.
- `rd_eof`  out  1  `user_r_gs_raw_signal_eof`.
- `adc_data`  in  16  front-end sample.
- `adc_valid`  in  1  one-cycle strobe per new sample.
- `stim_out`  out  1  click stimulus drive.
- `busy`  out  1  state ≠ IDLE.
- `overflow`  out  1  sticky: at least one sample dropped this run.

## Operation
- Command fields:
  - N = `cmd_data[15:0]`: sample count.
  - D = `cmd_data[23:16]`: keep one of every D+1 valid samples.
  - `cmd_data[31:24]` is ignored.
- States: IDLE, STIM, CAPTURE, DONE.
- IDLE:
  - `cmd_wren` with N≠0 and `rd_open`=1 latches N and D, clears `overflow`, the sample counter and the decimation counter, and moves to STIM.
  - Any other write is discarded.
- STIM: `stim_out`=1 for exactly STIM_LEN cycles, then CAPTURE. `adc_valid` is ignored.
- CAPTURE:
  - Each `adc_valid` with decimation counter = D stores `adc_data`, increments the sample counter and clears the decimation counter. Otherwise the decimation counter increments.
  - A stored sample with the FIFO full is dropped, but it still counts and sets `overflow`.
  - When the sample counter reaches N, move to DONE.
- DONE: FIFO keeps draining. `rd_eof` = `rd_empty` in this state.
- `rd_open` falling in any state: next cycle go to IDLE, flush the FIFO, drop `stim_out`. `overflow` holds its value.
- `cmd_full` = `busy`; host writes are blocked during a run.
- FIFO: synchronous, standard read. `rd_data` updates the cycle after a `rd_en` with `rd_empty`=0. `rd_en` while empty is ignored. Simultaneous read and write while full: the write is dropped (full evaluated before the read).

## Timing
- Reset values:
  - State: IDLE.
  - `cmd_full`, `busy`, `stim_out`, `overflow`, `rd_eof`: 0.
  - `rd_empty`: 1.
  - `rd_data`: 0x0000.
  - FIFO pointers and all counters: 0.
- Command accepted at edge k: `busy` and `cmd_full` are 1 and `stim_out` rises after edge k. `stim_out` falls after edge k+STIM_LEN, when the state becomes CAPTURE.
- Sample write: `adc_valid` at edge j writes at edge j. `rd_empty` deasserts after edge j (1-cycle write-to-empty latency).
- Read latency: 1 cycle from `rd_en` to `rd_data`.
- N-th stored sample at edge j: DONE after edge j. `rd_eof` rises the cycle after the last word is read.
- Counters: 16-bit sample counter, 8-bit decimation counter, no wrap (terminal count N ≤ 65535).
- Asynchronous reset mid-run aborts immediately and discards FIFO contents.

## Test plan
- Basic run:
  - Stimulus: `rd_open`=1, write 0x0000_0004 (N=4, D=0), `adc_valid` every 3 cycles with data 0x0101, 0x0202, 0x0303, 0x0404.
  - Required response: `stim_out` high exactly STIM_LEN cycles; reads return the four words in order; `rd_eof`=1 with `rd_empty`=1 afterwards; `overflow`=0.
- Decimation:
  - Stimulus: N=3, D=2, 9 samples with values 0..8.
  - Required response: FIFO holds 2, 5, 8; then DONE.
- Overflow:
  - Stimulus: FIFO_AW=2, N=6, D=0, no reads during capture.
  - Required response: first 4 samples stored; `overflow`=1; DONE after the 6th `adc_valid`; 4 reads then `rd_eof`.
- Rejection:
  - Stimulus: write N=0; write with `rd_open`=0; write while `busy`.
  - Required response: state stays as it was, `stim_out` never rises, `cmd_full`=1 only while busy.
- Abort:
  - Stimulus: drop `rd_open` mid-CAPTURE and mid-STIM.
  - Required response: IDLE next cycle, `stim_out`=0, `rd_empty`=1. Separately, assert `bus_rst_n`=0 asynchronously between edges: all outputs reach reset values immediately.

Source files
------------

// File: rtl/gs_test_sequencer.sv
// rtl/gs_test_sequencer.sv - evoked-potential run sequencer: click stimulus, decimated ADC capture, host read FIFO
module gs_test_sequencer #(
    parameter int FIFO_AW  = 10,
    parameter int STIM_LEN = 100
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        cmd_wren,
    input  logic [31:0] cmd_data,
    output logic        cmd_full,
    input  logic        rd_open,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        rd_empty,
    output logic        rd_eof,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    output logic        stim_out,
    output logic        busy,
    output logic        overflow
);
    localparam int SW = (STIM_LEN > 1) ? $clog2(STIM_LEN) : 1;
    localparam logic [SW-1:0] STIM_LAST = SW'(STIM_LEN - 1);

    typedef enum logic [1:0] {IDLE, STIM, CAPTURE, DONE} state_t;

    state_t            state, next_state;
    logic [15:0]       n_reg, sample_cnt;
    logic [7:0]        d_reg, dec_cnt;
    logic [SW-1:0]     stim_cnt;
    logic [FIFO_AW:0]  wr_ptr, rd_ptr;
    logic [15:0]       mem [2**FIFO_AW];
    logic              fifo_full, flush, accept, take, store, last_sample, wr_ok, rd_ok;
    logic              unused_cmd_bits;

    assign unused_cmd_bits = ^cmd_data[31:24];

    assign rd_empty  = (wr_ptr == rd_ptr);
    assign fifo_full = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                       (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    assign busy      = (state != IDLE);
    assign cmd_full  = busy;
    assign stim_out  = (state == STIM);
    assign rd_eof    = (state == DONE) && rd_empty;

    // Closing the read stream aborts the run from any state on the next edge.
    always_comb begin
        flush       = !rd_open;
        accept      = (state == IDLE) && cmd_wren && (cmd_data[15:0] != 16'd0) && rd_open;
        take        = (state == CAPTURE) && adc_valid && rd_open;
        store       = take && (dec_cnt == d_reg);
        last_sample = store && ((sample_cnt + 16'd1) == n_reg);
        wr_ok       = store && !fifo_full;
        rd_ok       = rd_en && !rd_empty && !flush;
        next_state  = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) next_state = STIM;
                STIM:    if (stim_cnt == STIM_LAST) next_state = CAPTURE;
                CAPTURE: if (last_sample) next_state = DONE;
                DONE:    next_state = DONE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            state      <= IDLE;
            n_reg      <= '0;
            d_reg      <= '0;
            sample_cnt <= '0;
            dec_cnt    <= '0;
            stim_cnt   <= '0;
            overflow   <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                n_reg      <= cmd_data[15:0];
                d_reg      <= cmd_data[23:16];
                sample_cnt <= '0;
                dec_cnt    <= '0;
                stim_cnt   <= '0;
                overflow   <= 1'b0;
            end else begin
                if (state == STIM && !flush) stim_cnt <= stim_cnt + 1'b1;
                if (store) begin
                    sample_cnt <= sample_cnt + 16'd1;
                    dec_cnt    <= '0;
                    if (fifo_full) overflow <= 1'b1;
                end else if (take) begin
                    dec_cnt <= dec_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr[FIFO_AW-1:0]];
            end
        end
    end

    // Storage carries no reset; the pointers alone define valid contents.
    always_ff @(posedge bus_clk) begin
        if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= adc_data;
    end
endmodule
